// File: rtl/spi_master_mb.sv
// spi_master_mb: 3-wire SPI master for converter configuration ports.
// Streams 1-4 data bytes per frame with a programmable SCLK divider and NUM_CS selects.
module spi_master_mb #(
  parameter int ADDR_W  = 13,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [2:0]        cs_sel,
  input  logic [1:0]        nbytes,
  input  logic [ADDR_W-1:0] addr_tx,
  input  logic [31:0]       data_tx,
  output logic [31:0]       data_rx,
  output logic              busy,
  output logic              done,
  output logic              rdy,
  output logic              err,
  output logic              SCLK,
  inout  wire               SDIO,
  output logic [NUM_CS-1:0] CSB
);

  localparam int FW = 3 + ADDR_W + 32;
  localparam int BW = $clog2(FW + 1);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] DATA_START = BW'(3 + ADDR_W);
  localparam logic [BW-1:0] ADDR_LAST  = BW'(2 + ADDR_W);
  localparam logic [BW-1:0] HDR_LAST   = BW'(10 + ADDR_W);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD, ST_DONE} state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [BW-1:0]     bit_num_r;
  logic [BW-1:0]     bit_last_r;
  logic [FW-2:0]     frame_r;
  logic [31:0]       rx_sh_r;
  logic [31:0]       data_rx_r;
  logic [NUM_CS-1:0] csb_r;
  logic              is_rd_r;
  logic              sclk_r;
  logic              sdio_out_r;
  logic              sdio_oe_r;
  logic              busy_r;
  logic              done_r;
  logic              rdy_r;
  logic              err_r;

  logic              cs_bad_s;
  logic [31:0]       data_al_s;
  logic [BW-1:0]     bit_last_s;
  logic [NUM_CS-1:0] csb_sel_s;

  // Request decode: select validity, MSB-aligned write data and final bit index of the frame.
  always_comb begin
    cs_bad_s   = ({29'd0, cs_sel} >= 32'(NUM_CS));
    data_al_s  = data_tx << {(2'd3 - nbytes), 3'b000};
    bit_last_s = HDR_LAST + BW'({nbytes, 3'b000});
    csb_sel_s  = ~(NUM_CS'(1'b1) << cs_sel);
  end

  // Transfer sequencer: framing, SCLK generation, SDIO drive/capture and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      bit_num_r  <= '0;
      bit_last_r <= '0;
      frame_r    <= '0;
      rx_sh_r    <= '0;
      data_rx_r  <= '0;
      csb_r      <= '1;
      is_rd_r    <= 1'b0;
      sclk_r     <= 1'b0;
      sdio_out_r <= 1'b0;
      sdio_oe_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rdy_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      rdy_r  <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sclk_r     <= 1'b0;
          csb_r      <= '1;
          sdio_out_r <= 1'b0;
          sdio_oe_r  <= 1'b1;
          if (rd || wr) begin
            busy_r <= 1'b1;
            if (cs_bad_s) begin
              err_r   <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              // rd wins when both are requested; the R/W bit goes straight onto SDIO
              is_rd_r    <= rd;
              frame_r    <= {nbytes, addr_tx, data_al_s};
              sdio_out_r <= rd;
              csb_r      <= csb_sel_s;
              cnt_r      <= '0;
              bit_num_r  <= '0;
              bit_last_r <= bit_last_s;
              rx_sh_r    <= '0;
              state_r    <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            sclk_r <= ~sclk_r;
            if (!sclk_r) begin
              if (is_rd_r && (bit_num_r >= DATA_START)) begin
                rx_sh_r <= {rx_sh_r[30:0], SDIO};
              end
            end else if (bit_num_r == bit_last_r) begin
              state_r <= ST_HOLD;
            end else begin
              bit_num_r  <= bit_num_r + BW'(1'b1);
              sdio_out_r <= frame_r[FW-2];
              frame_r    <= {frame_r[FW-3:0], 1'b0};
              if (is_rd_r && (bit_num_r == ADDR_LAST)) begin
                sdio_oe_r <= 1'b0;
              end
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        ST_HOLD: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r      <= '0;
            csb_r      <= '1;
            sdio_out_r <= 1'b0;
            sdio_oe_r  <= 1'b1;
            done_r     <= 1'b1;
            state_r    <= ST_DONE;
            if (is_rd_r) begin
              rdy_r     <= 1'b1;
              data_rx_r <= rx_sh_r;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        ST_DONE: begin
          if (!wr && !rd) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign SDIO    = sdio_oe_r ? sdio_out_r : 1'bz;
  assign SCLK    = sclk_r;
  assign CSB     = csb_r;
  assign data_rx = data_rx_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign rdy     = rdy_r;
  assign err     = err_r;

endmodule

// File: tb/tb_spi_master_mb.sv
// Directed bench for spi_master_mb: a transfer table checked through a bus monitor and
// slave model, plus reset, reject, held-request and rd/wr priority sequences.
module tb_spi_master_mb;

  localparam int ADDR_W  = 13;
  localparam int CLK_DIV = 2;
  localparam int NUM_CS  = 4;
  localparam int DS      = 3 + ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr;
  logic              rd;
  logic [2:0]        cs_sel;
  logic [1:0]        nbytes;
  logic [ADDR_W-1:0] addr_tx;
  logic [31:0]       data_tx;
  logic [31:0]       data_rx;
  logic              busy;
  logic              done;
  logic              rdy;
  logic              err;
  logic              SCLK;
  wire               SDIO;
  logic [NUM_CS-1:0] CSB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master_mb #(.ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .NUM_CS(NUM_CS)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .cs_sel(cs_sel), .nbytes(nbytes),
    .addr_tx(addr_tx), .data_tx(data_tx), .data_rx(data_rx), .busy(busy),
    .done(done), .rdy(rdy), .err(err), .SCLK(SCLK), .SDIO(SDIO), .CSB(CSB)
  );

  // Bus monitor: SCLK rises, bits seen on rise, CSB low run lengths, status pulse counts.
  logic        sclk_prev = 1'b0;
  int          rise_cnt = 0;
  int          rise_total = 0;
  int          done_total = 0;
  int          rdy_total = 0;
  int          err_total = 0;
  int          rdy_alone = 0;
  logic [63:0] cap = 64'd0;
  int          run_len  [NUM_CS] = '{default: 0};
  int          last_len [NUM_CS] = '{default: 0};
  int          runs     [NUM_CS] = '{default: 0};

  always @(negedge clk) begin
    sclk_prev <= SCLK;
    if (SCLK && !sclk_prev) begin
      rise_total <= rise_total + 1;
      cap        <= {cap[62:0], SDIO};
    end
    if (&CSB) rise_cnt <= 0;
    else if (SCLK && !sclk_prev) rise_cnt <= rise_cnt + 1;
    done_total <= done_total + int'(done);
    rdy_total  <= rdy_total + int'(rdy);
    err_total  <= err_total + int'(err);
    if (rdy && !done) rdy_alone <= rdy_alone + 1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!CSB[i]) begin
        run_len[i] <= run_len[i] + 1;
      end else if (run_len[i] != 0) begin
        last_len[i] <= run_len[i];
        runs[i]     <= runs[i] + 1;
        run_len[i]  <= 0;
      end
    end
  end

  // Slave model: drives read data MSB first once the master has released SDIO.
  logic        slv_en;
  logic [31:0] slv_data;
  int          slv_nbits;
  logic        slv_drv;
  logic        slv_bit;
  logic [4:0]  slv_idx;

  always_comb begin
    slv_drv = slv_en && !(&CSB) && (rise_cnt >= DS) && (rise_cnt < DS + slv_nbits)
              && !((rise_cnt == DS) && sclk_prev && SCLK);
    slv_idx = 5'(slv_nbits - 1 - (rise_cnt - DS));
    slv_bit = slv_drv ? slv_data[slv_idx] : 1'b0;
  end

  assign SDIO = slv_drv ? slv_bit : 1'bz;

  typedef struct {
    logic              is_rd;
    logic [2:0]        cs;
    logic [1:0]        nb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       payload;
    int                exp_csb_len;
    logic [31:0]       exp_rx;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      step(1);
      if (done) got = 1'b1;
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic r, input logic [1:0] nb,
                                            input logic [ADDR_W-1:0] a, input logic [31:0] p);
    logic [63:0] f;
    int nd;
    nd = 8 * (int'(nb) + 1);
    f  = 64'({r, nb, a});
    f  = (f << nd) | ({32'd0, p} & ((64'd1 << nd) - 64'd1));
    return f;
  endfunction

  function automatic int runs_sum();
    int s = 0;
    for (int i = 0; i < NUM_CS; i++) s += runs[i];
    return s;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int          rises0;
    int          runs0 [NUM_CS];
    int          b;
    bit          got;
    logic [63:0] mask;
    b      = DS + 8 * (int'(v.nb) + 1);
    mask   = (64'd1 << b) - 64'd1;
    rises0 = rise_total;
    for (int i = 0; i < NUM_CS; i++) runs0[i] = runs[i];
    slv_en    = v.is_rd;
    slv_data  = v.payload;
    slv_nbits = 8 * (int'(v.nb) + 1);
    cs_sel    = v.cs;
    nbytes    = v.nb;
    addr_tx   = v.addr;
    data_tx   = v.is_rd ? ~v.payload : v.payload;
    rd        = v.is_rd;
    wr        = !v.is_rd;
    step(2);
    // inputs scrambled after accept must not disturb the frame in flight
    cs_sel  = v.cs ^ 3'd1;
    nbytes  = ~v.nb;
    addr_tx = ~v.addr;
    data_tx = ~data_tx;
    wait_done(got);
    check({tag, "_done"}, 64'(got), 64'd1);
    check({tag, "_rdy"}, 64'(rdy), 64'(v.is_rd));
    check({tag, "_data_rx"}, 64'(data_rx), 64'(v.exp_rx));
    check({tag, "_csb_at_done"}, 64'(CSB), 64'(4'hF));
    rd = 1'b0;
    wr = 1'b0;
    step(3);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_frame"}, cap & mask, exp_frame(v.is_rd, v.nb, v.addr, v.payload));
    check({tag, "_rises"}, 64'(rise_total - rises0), 64'(b));
    check({tag, "_csb_len"}, 64'(last_len[int'(v.cs)]), 64'(v.exp_csb_len));
    for (int i = 0; i < NUM_CS; i++)
      check({tag, "_csb_runs"}, 64'(runs[i] - runs0[i]), 64'((i == int'(v.cs)) ? 1 : 0));
    slv_en = 1'b0;
  endtask

  initial begin
    bit got;
    int e0, r0, s0, d0;
    logic [2:0] bad_cs [2];

    vecs[0] = '{1'b0, 3'd1, 2'd0, 13'h0014, 32'h777777A5,  98, 32'h00000000};
    vecs[1] = '{1'b1, 3'd2, 2'd1, 13'h0100, 32'h00001234, 130, 32'h00001234};
    vecs[2] = '{1'b0, 3'd0, 2'd3, 13'h1FFF, 32'hDEADBEEF, 194, 32'h00001234};
    vecs[3] = '{1'b1, 3'd3, 2'd3, 13'h0AAA, 32'hCAFEF00D, 194, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 3'd3, 2'd2, 13'h0001, 32'hFF123456, 162, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 3'd0, 2'd0, 13'h1000, 32'h0000005A,  98, 32'h0000005A};
    bad_cs[0] = 3'd5;
    bad_cs[1] = 3'd4;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; cs_sel = 3'd0; nbytes = 2'd0;
    addr_tx = '0; data_tx = 32'd0; slv_en = 1'b0; slv_data = 32'd0; slv_nbits = 8;
    step(3);
    check("rst_csb", 64'(CSB), 64'(4'hF));
    check("rst_sclk", 64'(SCLK), 64'd0);
    check("rst_sdio", 64'(SDIO), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdy", 64'(rdy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_data_rx", 64'(data_rx), 64'd0);
    rst = 1'b0;
    step(2);

    // reset in the middle of the data phase of a 4-byte write
    cs_sel = 3'd2; nbytes = 2'd3; addr_tx = 13'h0555; data_tx = 32'h0F0F0F0F; wr = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      step(1);
      got = (rise_cnt >= DS + 4);
    end
    check("mid_reach_data", 64'(got), 64'd1);
    check("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    wr  = 1'b0;
    step(1);
    check("mid_rst_csb", 64'(CSB), 64'(4'hF));
    check("mid_rst_sclk", 64'(SCLK), 64'd0);
    check("mid_rst_sdio", 64'(SDIO), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    step(2);

    // out-of-range chip selects, including the first invalid index
    for (int k = 0; k < 2; k++) begin
      e0 = err_total; r0 = rise_total; s0 = runs_sum(); d0 = done_total;
      cs_sel = bad_cs[k]; nbytes = 2'd0; addr_tx = 13'h0010; data_tx = 32'h11; wr = 1'b1;
      step(12);
      check("rej_err_once", 64'(err_total - e0), 64'd1);
      check("rej_no_sclk", 64'(rise_total - r0), 64'd0);
      check("rej_no_csb", 64'(runs_sum() - s0), 64'd0);
      check("rej_csb_high", 64'(CSB), 64'(4'hF));
      check("rej_no_done", 64'(done_total - d0), 64'd0);
      wr = 1'b0;
      step(3);
      check("rej_idle_busy", 64'(busy), 64'd0);
    end

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // write request held far longer than the transfer
    d0 = done_total;
    cs_sel = 3'd1; nbytes = 2'd0; addr_tx = 13'h0033; data_tx = 32'h3C; wr = 1'b1;
    step(200);
    check("hold_busy_high", 64'(busy), 64'd1);
    check("hold_one_done", 64'(done_total - d0), 64'd1);
    check("hold_frame", cap & 64'hFFFFFF, exp_frame(1'b0, 2'd0, 13'h0033, 32'h3C));
    wr = 1'b0;
    step(3);
    check("hold_busy_low", 64'(busy), 64'd0);
    check("hold_still_one", 64'(done_total - d0), 64'd1);

    // wr and rd together: read takes priority
    slv_en = 1'b1; slv_data = 32'hC3; slv_nbits = 8;
    cs_sel = 3'd0; nbytes = 2'd0; addr_tx = 13'h0042; data_tx = 32'h0; wr = 1'b1; rd = 1'b1;
    wait_done(got);
    check("both_done", 64'(got), 64'd1);
    check("both_rdy", 64'(rdy), 64'd1);
    check("both_data_rx", 64'(data_rx), 64'h0C3);
    wr = 1'b0; rd = 1'b0;
    step(3);
    check("both_hdr_bit", 64'(cap[23]), 64'd1);
    check("both_frame", cap & 64'hFFFFFF, exp_frame(1'b1, 2'd0, 13'h0042, 32'hC3));
    slv_en = 1'b0;

    check("rdy_without_done", 64'(rdy_alone), 64'd0);
    check("rdy_total", 64'(rdy_total), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
